// File: rtl/core_mem_responder_pkg.sv
// core_mem_responder_pkg
//   Definitions shared by the memory responder and the cores that talk to it:
//   the M-stage enable encodings and the layout of a request address
//   {bank id, word address}.
package core_mem_responder_pkg;

  // M-stage enable encoding; 2'b11 is illegal and is treated as no request.
  typedef enum logic [1:0] {
    MEM_EN_NONE = 2'b00,
    MEM_EN_LD   = 2'b01,
    MEM_EN_ST   = 2'b10
  } mem_en_e;

  // Word address occupies the low REG_WIDTH bits of a request address.
  localparam int MEM_WORD_LSB = 0;

  function automatic int mem_word_msb(input int reg_width);
    return reg_width - 1;
  endfunction

  // Bank id sits directly above the word address.
  function automatic int mem_bank_lsb(input int reg_width);
    return reg_width;
  endfunction

  // True only for the two legal request encodings.
  function automatic logic mem_en_is_req(input logic [1:0] en);
    return (en == MEM_EN_LD) || (en == MEM_EN_ST);
  endfunction

endpackage

// File: rtl/core_mem_responder_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. Priority starts at ptr and ascends
//   with wrap-around; at most one grant is issued.
//   Ports:
//     req      in   per-requester request bits
//     ptr      in   index of the highest-priority requester this cycle
//     gnt      out  one-hot grant
//     gnt_idx  out  index of the granted requester (0 when none)
//     gnt_vld  out  1 when any grant is issued
module rr_arbiter #(
  parameter int CORE_COUNT = 4,
  parameter int IDX_W      = $clog2(CORE_COUNT)
) (
  input  logic [CORE_COUNT-1:0] req,
  input  logic [IDX_W-1:0]      ptr,
  output logic [CORE_COUNT-1:0] gnt,
  output logic [IDX_W-1:0]      gnt_idx,
  output logic                  gnt_vld
);

  logic [IDX_W-1:0] cand;

  // CORE_COUNT is a power of two, so the IDX_W-bit sum wraps naturally.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < CORE_COUNT; k++) begin
      cand = ptr + IDX_W'(k);
      if (!gnt_vld && req[cand]) begin
        gnt_vld   = 1'b1;
        gnt_idx   = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_mem_responder.sv
// core_mem_responder
//   Shared data memory serving the M-stage ports of CORE_COUNT cores. Memory
//   is split into CORE_COUNT banks selected by the bank-id field of the
//   address; every bank has its own round-robin arbiter so accesses to
//   different banks proceed in parallel.
//   Ports (per-core buses flattened, core i in slice i):
//     clk        in   rising-edge clock
//     reset      in   asynchronous active-high reset
//     enable_M   in   2 bits/core: 01 LD, 10 ST, 00/11 idle
//     addr_M     in   {bank id, word} per core
//     wr_data_M  in   store data per core
//     ready_M    out  one-cycle completion pulse per core
//     rd_data_M  out  load data per core, zero unless ready_M is set
module core_mem_responder
  import core_mem_responder_pkg::*;
#(
  parameter int CORE_COUNT    = 4,
  parameter int CORE_ID_WIDTH = 2,
  parameter int REG_WIDTH     = 8,
  parameter int BANK_DEPTH    = 256
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [2*CORE_COUNT-1:0]                   enable_M,
  input  logic [(CORE_ID_WIDTH+REG_WIDTH)*CORE_COUNT-1:0] addr_M,
  input  logic [REG_WIDTH*CORE_COUNT-1:0]           wr_data_M,
  output logic [CORE_COUNT-1:0]                     ready_M,
  output logic [REG_WIDTH*CORE_COUNT-1:0]           rd_data_M
);

  localparam int AW       = CORE_ID_WIDTH + REG_WIDTH;
  localparam int BANK_LSB = mem_bank_lsb(REG_WIDTH);

  // Unpacked per-core request fields
  logic [1:0]               core_en    [CORE_COUNT];
  logic [CORE_ID_WIDTH-1:0] core_bank  [CORE_COUNT];
  logic [REG_WIDTH-1:0]     core_word  [CORE_COUNT];
  logic [REG_WIDTH-1:0]     core_wdata [CORE_COUNT];

  // inflight doubles as the ready pulse: it is set exactly at the grant edge
  // and cleared at the following one.
  logic [CORE_COUNT-1:0]                     inflight_q, inflight_d;
  logic [CORE_COUNT-1:0][REG_WIDTH-1:0]      rd_q, rd_d;
  logic [CORE_COUNT-1:0][CORE_ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;

  // Per-bank arbitration results, indexed [bank][core] / [bank]
  logic [CORE_COUNT-1:0][CORE_COUNT-1:0]     bank_req;
  logic [CORE_COUNT-1:0][CORE_COUNT-1:0]     gnt_oh;
  logic [CORE_COUNT-1:0][CORE_ID_WIDTH-1:0]  gnt_idx;
  logic [CORE_COUNT-1:0]                     gnt_vld;
  logic [CORE_COUNT-1:0][REG_WIDTH-1:0]      bank_word;

  always_comb begin
    for (int i = 0; i < CORE_COUNT; i++) begin
      core_en[i]    = enable_M[2*i +: 2];
      core_bank[i]  = addr_M[AW*i + BANK_LSB +: CORE_ID_WIDTH];
      core_word[i]  = addr_M[AW*i + MEM_WORD_LSB +: REG_WIDTH];
      core_wdata[i] = wr_data_M[REG_WIDTH*i +: REG_WIDTH];
    end
  end

  // A core whose access is in flight is still holding its old request; it is
  // masked so the same instruction is not served twice.
  always_comb begin
    bank_req = '0;
    for (int b = 0; b < CORE_COUNT; b++) begin
      for (int i = 0; i < CORE_COUNT; i++) begin
        bank_req[b][i] = mem_en_is_req(core_en[i]) &&
                         (core_bank[i] == CORE_ID_WIDTH'(b)) &&
                         !inflight_q[i];
      end
    end
  end

  for (genvar b = 0; b < CORE_COUNT; b++) begin : g_bank
    logic [REG_WIDTH-1:0] mem [BANK_DEPTH];

    rr_arbiter #(
      .CORE_COUNT (CORE_COUNT),
      .IDX_W      (CORE_ID_WIDTH)
    ) u_arb (
      .req     (bank_req[b]),
      .ptr     (rr_ptr_q[b]),
      .gnt     (gnt_oh[b]),
      .gnt_idx (gnt_idx[b]),
      .gnt_vld (gnt_vld[b])
    );

    // Single port: the granted core either writes or reads this cycle.
    always_ff @(posedge clk) begin
      if (gnt_vld[b] && (core_en[gnt_idx[b]] == MEM_EN_ST)) begin
        mem[core_word[gnt_idx[b]]] <= core_wdata[gnt_idx[b]];
      end
    end

    assign bank_word[b] = mem[core_word[gnt_idx[b]]];
  end

  always_comb begin
    inflight_d = '0;
    rd_d       = rd_q;
    rr_ptr_d   = rr_ptr_q;
    for (int b = 0; b < CORE_COUNT; b++) begin
      if (gnt_vld[b]) begin
        rr_ptr_d[b] = gnt_idx[b] + 1'b1;
      end
    end
    // Each core addresses exactly one bank, so at most one bank grants it.
    // A granted store leaves zero in rd_q so its response data reads as 0.
    for (int g = 0; g < CORE_COUNT; g++) begin
      for (int b = 0; b < CORE_COUNT; b++) begin
        if (gnt_oh[b][g]) begin
          inflight_d[g] = 1'b1;
          rd_d[g]       = (core_en[g] == MEM_EN_LD) ? bank_word[b] : '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q <= '0;
      rd_q       <= '0;
      rr_ptr_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      rd_q       <= rd_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  always_comb begin
    ready_M   = inflight_q;
    rd_data_M = '0;
    for (int g = 0; g < CORE_COUNT; g++) begin
      if (inflight_q[g]) begin
        rd_data_M[REG_WIDTH*g +: REG_WIDTH] = rd_q[g];
      end
    end
  end

endmodule
